// File: rtl/aurora_rx_buffer.sv
// Elastic receive buffer between the Aurora 64B/66B RX user interface and the RDMA datapath.
// It qualifies the raw channel-up signal, buffers beats in a FIFO and counts the beats dropped while the FIFO is full.
module aurora_rx_buffer #(
  parameter int DATA_WIDTH  = 256,
  parameter int DEPTH_LOG2  = 5,
  parameter int UP_DEBOUNCE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_channel_up,
  input  logic [DATA_WIDTH-1:0] AXIS_RX_TDATA,
  input  logic                  AXIS_RX_TVALID,
  input  logic                  AXIS_RX_TLAST,
  output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                  AXIS_OUT_TVALID,
  output logic                  AXIS_OUT_TLAST,
  input  logic                  AXIS_OUT_TREADY,
  output logic                  channel_up,
  output logic                  overrun,
  output logic [15:0]           drop_count,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] DOWN    = 2'd0;
  localparam logic [1:0] QUALIFY = 2'd1;
  localparam logic [1:0] UP      = 2'd2;

  localparam logic [15:0]           DEB     = 16'(UP_DEBOUNCE);
  localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [1:0]            state;
  logic [15:0]           qual_count;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Losing the link while UP empties the FIFO; fullness is judged on the registered level only.
  always_comb begin
    flush = (state == UP) && !rx_channel_up;
    push  = (state == UP) && rx_channel_up && AXIS_RX_TVALID && (level != FULL);
    drop  = (state == UP) && rx_channel_up && AXIS_RX_TVALID && (level == FULL);
    pop   = (level != '0) && AXIS_OUT_TREADY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DOWN;
      qual_count <= '0;
    end else begin
      case (state)
        DOWN: begin
          if (rx_channel_up) begin
            qual_count <= 16'd1;
            state      <= (DEB <= 16'd1) ? UP : QUALIFY;
          end
        end
        QUALIFY: begin
          if (!rx_channel_up) begin
            state <= DOWN;
          end else begin
            qual_count <= qual_count + 16'd1;
            if (qual_count + 16'd1 >= DEB) state <= UP;
          end
        end
        UP: begin
          if (!rx_channel_up) state <= DOWN;
        end
        default: state <= DOWN;
      endcase
    end
  end

  // Storage needs no reset; valid contents are tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {AXIS_RX_TLAST, AXIS_RX_TDATA};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      overrun <= drop;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  assign channel_up      = (state == UP);
  assign AXIS_OUT_TVALID = (level != '0);
  assign {AXIS_OUT_TLAST, AXIS_OUT_TDATA} = mem[rd_ptr];
  assign fifo_level      = level;

endmodule
